// File: rtl/bram_pkg.sv
// Shared encodings for the parametrised simple dual-port block RAM:
// read-during-write modes and the clear sequencer state.
package bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // True when a word splits into whole byte lanes.
    function automatic bit lanes_ok(input int data_width, input int byte_width);
        return (byte_width > 0) && ((data_width % byte_width) == 0);
    endfunction

endpackage

// File: rtl/bram_sdp_param_if.sv
// User-side bus of bram_sdp_param: write port A, read port B, status and
// the clear sequencer state for observation.
interface bram_sdp_param_if
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    // ena/enb are the request valids and !busy is the shared ready: a write
    // or read is taken on a rising edge where its enable is 1 and busy is 0;
    // a request seen while busy is dropped, never held or retried.
    logic                  ena;
    logic [NB-1:0]         wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dia;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dob;
    logic                  dob_valid;
    logic                  busy;
    clr_state_e            clr_state;

    modport master (
        output ena, wea, addra, dia, enb, addrb,
        input  dob, dob_valid, busy, clr_state
    );

    modport slave (
        input  ena, wea, addra, dia, enb, addrb,
        output dob, dob_valid, busy, clr_state
    );

endinterface

// File: rtl/bram_clear_fsm.sv
// Clear-on-reset sequencer: after reset release, sweeps every address once
// and holds busy high until the last word has been written.
module bram_clear_fsm
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output clr_state_e            state_o
);

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;

    // IDLE with busy set means a sweep is pending; it starts on the first
    // edge after reset release so an abort always restarts from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (busy_q) begin
                        state_q <= CLR_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLR_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= CLR_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= CLR_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = (state_q == CLR_CLEAR);
    assign clr_addr_o = cnt_q;
    assign state_o    = state_q;

endmodule

// File: rtl/bram_sdp_param.sv
// Single-clock simple dual-port RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output register and clear-on-reset.
module bram_sdp_param
    import bram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    OUT_REG        = 0,
    parameter int                    RDW_MODE       = RDW_READ_FIRST,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic             clk,
    input logic             rst,
    bram_sdp_param_if.slave bus
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (!lanes_ok(DATA_WIDTH, BYTE_WIDTH) || (ADDR_WIDTH < 1)) begin : g_bad_cfg
        $error("bram_sdp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH and ADDR_WIDTH >= 1");
    end

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    clr_state_e            clr_state;

    bram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .state_o    (clr_state)
    );

    logic                  user_we;
    logic                  rd_acc;
    logic [NB-1:0]         wr_lanes;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // The sequencer owns port A while busy; user traffic is gated off then.
    always_comb begin
        user_we  = bus.ena & ~busy;
        rd_acc   = bus.enb & ~busy;
        wr_lanes = '0;
        wr_addr  = bus.addra;
        wr_data  = bus.dia;
        if (clr_we) begin
            wr_lanes = '1;
            wr_addr  = clr_addr;
            wr_data  = CLEAR_VALUE;
        end else if (user_we) begin
            wr_lanes = bus.wea;
        end
    end

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lanes[i]) begin
                ram_q[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_d;

    // Array read sees pre-write contents; write-first bypasses enabled lanes.
    always_comb begin
        rd_d = ram_q[bus.addrb];
        if ((RDW_MODE == RDW_WRITE_FIRST) && user_we && (bus.addra == bus.addrb)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wea[i]) begin
                    rd_d[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.dia[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_acc;
            if (rd_acc) begin
                rd_q <= rd_d;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] dob_q;
        logic                  dob_vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dob_q     <= '0;
                dob_vld_q <= 1'b0;
            end else begin
                dob_vld_q <= rd_vld_q;
                if (rd_vld_q) begin
                    dob_q <= rd_q;
                end
            end
        end

        assign bus.dob       = dob_q;
        assign bus.dob_valid = dob_vld_q;
    end else begin : g_no_out_reg
        assign bus.dob       = rd_q;
        assign bus.dob_valid = rd_vld_q;
    end

    assign bus.busy      = busy;
    assign bus.clr_state = clr_state;

endmodule
